// File: rtl/adder_share_arb.sv
// Shares one adder_nbit between NREQ valid/ready requesters. A round-robin arbiter
// grants one request at a time. Define ADDER_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.

module adder_nbit #(
  parameter int N = 10
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   sum_o
);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i};
endmodule

module adder_share_arb #(
  parameter int N    = 10,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  typedef struct packed {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [IDW-1:0] id;
  } op_t;

  state_t                   state_q, state_d;
  op_t                      op_q;
  logic                     rsp_valid_q;
  logic [N:0]               rsp_sum_q;
  logic [IDW-1:0]           rsp_id_q;
  logic [NREQ-1:0][N-1:0]   a_arr, b_arr;
  logic                     gnt_found;
  logic [IDW-1:0]           gnt_idx;
  logic                     accept;
  logic [N:0]               sum_w;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end

`ifdef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    // Descending scan so the lowest valid index is the last one written.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] scan_idx;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Pointer moves only on an accept, so a waiting requester keeps its turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end
`endif

  assign accept = (state_q == IDLE) && gnt_found;

  always_comb begin
    req_ready = '0;
    if (rst_n && accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  adder_nbit #(.N(N)) u_add (
    .a_i   (op_q.a),
    .b_i   (op_q.b),
    .sum_o (sum_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q.a  <= a_arr[gnt_idx];
        op_q.b  <= b_arr[gnt_idx];
        op_q.id <= gnt_idx;
      end
      if (state_q == CALC) begin
        rsp_sum_q   <= sum_w;
        rsp_id_q    <= op_q.id;
        rsp_valid_q <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: reset, sums with carry, arbitration order,
// backpressure, reset mid-flight and idle behaviour.

module tb_adder_share_arb;
  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;

  int nvec = 0;
  int nerr = 0;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  int exp_g[5] = '{0, 0, 0, 0, 0};
  int exp_s[5] = '{3, 3, 3, 3, 3};
`else
  int exp_g[5] = '{0, 1, 2, 3, 0};
  int exp_s[5] = '{3, 6, 67, 16, 3};
`endif

  adder_share_arb #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*N +: N] = N'(a);
    req_b[i*N +: N] = N'(b);
  endtask

  // Present one request, wait (bounded) for its grant, then check the response.
  task automatic do_req(input int i, input int a, input int b, input int exp_sum);
    int n;
    set_op(i, a, b);
    req_valid = NREQ'(1 << i);
    #1;
    n = 0;
    while (req_ready !== NREQ'(1 << i) && n < 8) begin
      tick();
      n++;
    end
    chk("req_gnt", 32'(req_ready), 32'(1 << i));
    tick();
    req_valid = '0;
    tick();
    chk("req_rsp_valid", 32'(rsp_valid), 1);
    chk("req_rsp_sum", 32'(rsp_sum), exp_sum);
    chk("req_rsp_id", 32'(rsp_id), i);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_id", 32'(rsp_id), 0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single request with latency check
    set_op(0, 2, 2);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_calc_ready", 32'(req_ready), 0);
    chk("t1_calc_valid", 32'(rsp_valid), 0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_sum", 32'(rsp_sum), 4);
    chk("t1_id", 32'(rsp_id), 0);
    tick();
    chk("t1_consumed", 32'(rsp_valid), 0);

    // Carry-out and plain sums
    do_req(2, 1023, 1023, 2046);
    do_req(1, 100, 20, 120);

    // Fairness with all four held valid from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(0, 3, 0); set_op(1, 1, 5); set_op(2, 45, 22); set_op(3, 7, 9);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(req_ready), 32'(1 << exp_g[k]));
      tick();
      chk("rr_calc_ready", 32'(req_ready), 0);
      tick();
      chk("rr_valid", 32'(rsp_valid), 1);
      chk("rr_sum", 32'(rsp_sum), exp_s[k]);
      chk("rr_id", 32'(rsp_id), exp_g[k]);
      tick();
    end
    req_valid = '0;

    // Backpressure: response must hold for 5 stalled cycles
    set_op(3, 500, 12); set_op(0, 1, 1);
    req_valid = 4'b1000; rsp_ready = 1'b0;
    #1;
    chk("bp_gnt", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    #1;
    chk("bp_calc_ready", 32'(req_ready), 0);
    tick();
    chk("bp_valid0", 32'(rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_sum", 32'(rsp_sum), 512);
      chk("bp_hold_id", 32'(rsp_id), 3);
      chk("bp_hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_consumed", 32'(rsp_valid), 0);
    chk("bp_next_gnt", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("bp_next_sum", 32'(rsp_sum), 2);
    chk("bp_next_id", 32'(rsp_id), 0);
    tick();

    // Reset while in CALC discards the transaction
    set_op(2, 9, 9);
    req_valid = 4'b0100;
    #1;
    chk("mr_gnt", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1010;
    rst_n = 1'b0;
    tick();
    chk("mr_valid", 32'(rsp_valid), 0);
    chk("mr_ready_in_rst", 32'(req_ready), 0);
    rst_n = 1'b1;
    set_op(1, 4, 4); set_op(3, 6, 6);
    #1;
    chk("mr_first_gnt", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("mr_calc_valid", 32'(rsp_valid), 0);
    tick();
    chk("mr_sum1", 32'(rsp_sum), 8);
    chk("mr_id1", 32'(rsp_id), 1);
    tick();
    chk("mr_second_gnt", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    chk("mr_sum3", 32'(rsp_sum), 12);
    chk("mr_id3", 32'(rsp_id), 3);
    tick();

    // Idle with rsp_ready pulses
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      rsp_ready = k[0];
      tick();
      chk("idle_ready", 32'(req_ready), 0);
      chk("idle_valid", 32'(rsp_valid), 0);
    end
    rsp_ready = 1'b1;
    set_op(0, 7, 8);
    req_valid = 4'b0001;
    #1;
    chk("idle_exit_gnt", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("idle_exit_sum", 32'(rsp_sum), 15);
    chk("idle_exit_id", 32'(rsp_id), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
